// File: rtl/iact_glb_read_arbiter_pkg.sv
// rtl/iact_glb_read_arbiter_pkg.sv - shared state encoding and width helpers for the iact GLB read arbiter
package iact_arb_pkg;

  typedef logic [0:0] arb_state_t;

  localparam arb_state_t IDLE  = 1'b0;
  localparam arb_state_t ISSUE = 1'b1;

  function automatic int ptr_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int beat_width(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/iact_glb_read_arbiter_rr_pick.sv
// rtl/iact_glb_read_arbiter_rr_pick.sv - combinational round-robin pick starting after ptr
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [PTR_W-1:0]   pick_idx
);

  // Walk farthest-first so the nearest set bit after ptr is the last to write.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % NUM_REQ]) begin
        pick     = NUM_REQ'(1) << ((int'(ptr) + i) % NUM_REQ);
        pick_idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/iact_glb_read_arbiter.sv
// rtl/iact_glb_read_arbiter.sv - round-robin burst arbiter sharing one GLB iact read port among NUM_REQ routers
module iact_glb_read_arbiter
  import iact_arb_pkg::*;
#(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10,
  parameter int NUM_REQ           = 3,
  parameter int BURST_LEN         = 5,
  parameter int GLB_LATENCY       = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_i,
  input  logic [NUM_REQ*ADDR_BITWIDTH_GLB-1:0] addr_i,
  output logic [NUM_REQ-1:0]                   gnt_o,
  output logic                                 glb_req_o,
  output logic [ADDR_BITWIDTH_GLB-1:0]         glb_addr_o,
  input  logic signed [DATA_BITWIDTH-1:0]      glb_data_i,
  output logic signed [DATA_BITWIDTH-1:0]      resp_data_o,
  output logic [NUM_REQ-1:0]                   resp_valid_o,
  output logic                                 busy_o
);

  localparam int PW = ptr_width(NUM_REQ);
  localparam int BW = beat_width(BURST_LEN);

  arb_state_t          state;
  logic [PW-1:0]       ptr;
  logic [BW-1:0]       beat_cnt;
  logic [NUM_REQ-1:0]  pick;
  logic [PW-1:0]       pick_idx;
  logic                last_beat;
  logic [GLB_LATENCY-1:0] pipe_vld;
  logic [PW-1:0]       pipe_id [GLB_LATENCY];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PW)
  ) u_rr_pick (
    .req      (req_i),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // ptr holds the granted index for the whole burst, so it doubles as the mux select.
  always_comb begin
    glb_req_o  = 1'b0;
    glb_addr_o = '0;
    if (state == ISSUE) begin
      glb_req_o  = req_i[ptr];
      glb_addr_o = addr_i[int'(ptr)*ADDR_BITWIDTH_GLB +: ADDR_BITWIDTH_GLB];
    end
  end

  assign last_beat = (beat_cnt == BW'(BURST_LEN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= PW'(NUM_REQ - 1);
      beat_cnt <= '0;
      gnt_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_i) begin
            gnt_o    <= pick;
            ptr      <= pick_idx;
            beat_cnt <= '0;
            state    <= ISSUE;
          end
        end
        default: begin
          if (glb_req_o) begin
            beat_cnt <= beat_cnt + BW'(1);
          end
          if (!glb_req_o || last_beat) begin
            gnt_o <= '0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Tag each issued read with its requester so the data can be steered on return.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld <= '0;
      for (int i = 0; i < GLB_LATENCY; i++) begin
        pipe_id[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= glb_req_o;
      pipe_id[0]  <= ptr;
      for (int i = 1; i < GLB_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

  always_comb begin
    resp_valid_o = '0;
    if (pipe_vld[GLB_LATENCY-1]) begin
      resp_valid_o[pipe_id[GLB_LATENCY-1]] = 1'b1;
    end
  end

  assign resp_data_o = glb_data_i;
  assign busy_o      = (state == ISSUE) || (|pipe_vld);

endmodule

// File: tb/tb_iact_glb_read_arbiter.sv
// tb/tb_iact_glb_read_arbiter.sv - scoreboard bench for the iact GLB read arbiter
module tb_iact_glb_read_arbiter;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int N  = 3;
  localparam int BL = 5;
  localparam int L  = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         req_i;
  logic [N*AW-1:0]      addr_i;
  logic [N-1:0]         gnt_o;
  logic                 glb_req_o;
  logic [AW-1:0]        glb_addr_o;
  logic signed [DW-1:0] glb_data_i;
  logic signed [DW-1:0] resp_data_o;
  logic [N-1:0]         resp_valid_o;
  logic                 busy_o;

  always #5 clk = ~clk;

  iact_glb_read_arbiter #(
    .DATA_BITWIDTH     (DW),
    .ADDR_BITWIDTH_GLB (AW),
    .NUM_REQ           (N),
    .BURST_LEN         (BL),
    .GLB_LATENCY       (L)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_i        (req_i),
    .addr_i       (addr_i),
    .gnt_o        (gnt_o),
    .glb_req_o    (glb_req_o),
    .glb_addr_o   (glb_addr_o),
    .glb_data_i   (glb_data_i),
    .resp_data_o  (resp_data_o),
    .resp_valid_o (resp_valid_o),
    .busy_o       (busy_o)
  );

  // GLB memory: word at address a reads back as a+1000, L cycles after the strobe.
  logic signed [DW-1:0] glb_pipe [L];
  always @(posedge clk) begin
    glb_pipe[0] <= glb_req_o ? DW'(int'(glb_addr_o) + 1000) : '0;
    for (int i = 1; i < L; i++) glb_pipe[i] <= glb_pipe[i-1];
  end
  assign glb_data_i = glb_pipe[L-1];

  typedef struct { int id; int data; int t; } rsp_t;
  typedef struct { int id; int start; int beats; } run_t;

  int     n_cmp = 0;
  int     n_err = 0;
  int     cyc;
  int     want  [N];
  int     start [N];
  int     baddr [N];
  logic [N-1:0] adv;
  logic [N-1:0] prev_gnt;
  rsp_t   sb[$];
  run_t   runs[$];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic drive();
    for (int n = 0; n < N; n++) begin
      req_i[n] = (want[n] > 0) && (cyc >= start[n]);
      addr_i[n*AW +: AW] = AW'(baddr[n]);
    end
  endtask

  task automatic monitor();
    rsp_t r;
    run_t u;
    int   g;
    chk("gnt_onehot", $onehot0(gnt_o), 1);
    chk("resp_onehot", $onehot0(resp_valid_o), 1);
    chk("busy", busy_o, (gnt_o != 0) || (sb.size() > 0));
    if (sb.size() > 0 && sb[0].t + L == cyc) chk("resp_due", resp_valid_o != 0, 1);
    if (resp_valid_o != 0) begin
      if (sb.size() == 0) begin
        chk("resp_spurious", resp_valid_o, 0);
      end else begin
        r = sb.pop_front();
        chk("resp_id", resp_valid_o, longint'(1) << r.id);
        chk("resp_data", resp_data_o, r.data);
        chk("resp_latency", cyc - r.t, L);
      end
    end
    if (gnt_o == 0) begin
      chk("idle_glb_req", glb_req_o, 0);
      chk("idle_glb_addr", glb_addr_o, 0);
    end else begin
      g = idx_of(gnt_o);
      chk("glb_req", glb_req_o, req_i[g]);
      if (prev_gnt != gnt_o) begin
        u.id = g; u.start = cyc; u.beats = 0;
        runs.push_back(u);
      end
      if (glb_req_o) begin
        chk("glb_addr", glb_addr_o, baddr[g]);
        r.id = g; r.data = baddr[g] + 1000; r.t = cyc;
        sb.push_back(r);
        u = runs.pop_back();
        u.beats++;
        runs.push_back(u);
      end
    end
    adv      = gnt_o & req_i;
    prev_gnt = gnt_o;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    for (int n = 0; n < N; n++) begin
      if (adv[n]) begin
        baddr[n]++;
        want[n]--;
      end
    end
    drive();
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) step();
  endtask

  task automatic clear_model();
    sb.delete();
    runs.delete();
    prev_gnt = '0;
    adv      = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int n = 0; n < N; n++) begin
      want[n] = 0; start[n] = 0; baddr[n] = 0;
    end
    cyc = 0;
    clear_model();
    drive();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    cyc = 0;
    drive();
  endtask

  task automatic chk_run(input int k, input int id, input int st, input int beats);
    if (k < runs.size()) begin
      chk($sformatf("run%0d_id", k), runs[k].id, id);
      chk($sformatf("run%0d_start", k), runs[k].start, st);
      chk($sformatf("run%0d_beats", k), runs[k].beats, beats);
    end else begin
      chk($sformatf("run%0d_present", k), runs.size(), k + 1);
    end
  endtask

  initial begin
    reset  = 1'b1;
    req_i  = '0;
    addr_i = '0;

    // Reset state, then a single 5-beat burst from requester 0.
    do_reset();
    chk("rst_gnt", gnt_o, 0);
    chk("rst_glb_req", glb_req_o, 0);
    chk("rst_glb_addr", glb_addr_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    want[0] = 5; baddr[0] = 100;
    drive();
    run(10);
    chk("single_runs", runs.size(), 1);
    chk_run(0, 0, 1, 5);
    chk("single_drained", sb.size(), 0);

    // All three contend: strict rotation with one bubble between bursts.
    do_reset();
    want[0] = 10; want[1] = 10; want[2] = 10;
    baddr[0] = 200; baddr[1] = 300; baddr[2] = 400;
    drive();
    run(40);
    chk("contend_runs", runs.size(), 6);
    chk_run(0, 0, 1, 5);
    chk_run(1, 1, 7, 5);
    chk_run(2, 2, 13, 5);
    chk_run(3, 0, 19, 5);
    chk_run(4, 1, 25, 5);
    chk_run(5, 2, 31, 5);
    chk("contend_drained", sb.size(), 0);

    // Requester 1 drops after two reads while 2 waits.
    do_reset();
    want[1] = 2; want[2] = 5;
    baddr[1] = 500; baddr[2] = 600;
    drive();
    run(14);
    chk("early_runs", runs.size(), 2);
    chk_run(0, 1, 1, 2);
    chk_run(1, 2, 5, 5);
    chk("early_drained", sb.size(), 0);

    // Requester 2 arrives mid-burst and is served right after requester 0.
    do_reset();
    want[0] = 10; want[2] = 5; start[2] = 3;
    baddr[0] = 700; baddr[2] = 800;
    drive();
    run(22);
    chk("fair_runs", runs.size(), 3);
    chk_run(0, 0, 1, 5);
    chk_run(1, 2, 7, 5);
    chk_run(2, 0, 13, 5);
    chk("fair_drained", sb.size(), 0);

    // Reset during the third beat with reads in flight.
    do_reset();
    want[0] = 10; baddr[0] = 900;
    drive();
    run(3);
    reset = 1'b1;
    #1;
    chk("midrst_gnt", gnt_o, 0);
    chk("midrst_glb_req", glb_req_o, 0);
    chk("midrst_resp_valid", resp_valid_o, 0);
    chk("midrst_busy", busy_o, 0);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    drive();
    run(14);
    chk("midrst_runs", runs.size(), 2);
    chk_run(0, 0, 1, 5);
    chk_run(1, 0, 7, 3);
    chk("midrst_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
